// File: rtl/veririsc_pkg.sv
// veririsc_pkg: opcode and phase codes shared by the sequence controller and its bench.
package veririsc_pkg;
  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;
  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;
  typedef enum logic {S_RUN, S_HALTED} state_e;
  function automatic logic is_aluop(input logic [2:0] op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction
endpackage

// File: rtl/seq_controller_if.sv
// seq_controller_if: instruction inputs and datapath strobes of the sequence controller.
interface seq_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       stall;
  logic [2:0] phase;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       inc_pc;
  logic       ld_pc;
  logic       ld_ac;
  logic       wr;
  logic       data_e;
  logic       halt;
  modport master (output opcode, zero, stall,
                  input phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt);
  modport slave  (input opcode, zero, stall,
                  output phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt);
endinterface

// File: rtl/phase_counter.sv
// phase_counter: 3-bit machine phase counter, wraps 7->0, advances only when enabled.
module phase_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [2:0] phase_o
);
  logic [2:0] phase_q, phase_d;
  assign phase_d = en_i ? phase_q + 3'd1 : phase_q;
  always_ff @(posedge clk) begin
    if (!rst_n) phase_q <= 3'd0;
    else phase_q <= phase_d;
  end
  assign phase_o = phase_q;
endmodule

// File: rtl/seq_controller.sv
// seq_controller: 8-phase instruction sequencer; halted flag plus combinational strobe decode.
module seq_controller
  import veririsc_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  seq_controller_if.slave bus
);
  state_e     state_q, state_d;
  logic [2:0] phase;
  logic       hlt_now, en, alu;
  assign hlt_now = (phase == OP_ADDR) && (bus.opcode == HLT);
  // HLT parks the counter at phase 4 both before and after the halted flag is set
  assign en  = !bus.stall && (state_q == S_RUN) && !hlt_now;
  assign alu = is_aluop(bus.opcode);
  phase_counter u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .phase_o (phase)
  );
  assign state_d = (state_q == S_RUN && hlt_now && !bus.stall) ? S_HALTED : state_q;
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_RUN;
    else state_q <= state_d;
  end
  assign bus.phase = phase;
  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    if (state_q == S_HALTED) bus.halt = 1'b1;
    else begin
      case (phase)
        INST_ADDR: bus.sel = 1'b1;
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = bus.opcode == HLT;
        end
        OP_FETCH: bus.rd = alu;
        ALU_OP: begin
          bus.rd     = alu;
          bus.inc_pc = bus.opcode == SKZ && bus.zero;
          bus.ld_pc  = bus.opcode == JMP;
          bus.data_e = bus.opcode == STO;
        end
        STORE: begin
          bus.rd     = alu;
          bus.ld_ac  = alu;
          bus.ld_pc  = bus.opcode == JMP;
          bus.wr     = bus.opcode == STO;
          bus.data_e = bus.opcode == STO;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: directed phase-by-phase checks of strobes, halt, stall and reset.
module tb_seq_controller;
  import veririsc_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  seq_controller_if bus ();
  seq_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}
  logic [7:0] vec;
  assign vec = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac, bus.wr, bus.data_e};
  logic [7:0] t_add [8] = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h10, 8'h40, 8'h40, 8'h44};
  logic [7:0] t_skz1[8] = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h10, 8'h00, 8'h10, 8'h00};
  logic [7:0] t_skz0[8] = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h10, 8'h00, 8'h00, 8'h00};
  logic [7:0] t_sto [8] = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h10, 8'h00, 8'h01, 8'h03};
  logic [7:0] t_jmp [8] = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h10, 8'h00, 8'h08, 8'h08};
  task automatic cyc(input string tag, input logic [2:0] ph, input logic [7:0] v, input logic h);
    tests += 3;
    assert (bus.phase === ph) else begin
      fails++;
      $error("FAIL %s phase: got %0d expected %0d", tag, bus.phase, ph);
    end
    assert (vec === v) else begin
      fails++;
      $error("FAIL %s strobes@%0d: got %b expected %b", tag, ph, vec, v);
    end
    assert (bus.halt === h) else begin
      fails++;
      $error("FAIL %s halt@%0d: got %b expected %b", tag, ph, bus.halt, h);
    end
    @(negedge clk);
  endtask
  task automatic run8(input string tag, input logic [7:0] t [8]);
    for (int i = 0; i < 8; i++) cyc(tag, 3'(i), t[i], 1'b0);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.opcode = ADD;
    bus.zero = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run8("add", t_add);
    bus.opcode = SKZ;
    bus.zero = 1'b1;
    run8("skz_z1", t_skz1);
    bus.zero = 1'b0;
    run8("skz_z0", t_skz0);
    bus.opcode = STO;
    run8("sto", t_sto);
    bus.opcode = JMP;
    run8("jmp", t_jmp);
    bus.opcode = HLT;
    for (int i = 0; i < 4; i++) cyc("hlt_pre", 3'(i), t_add[i], 1'b0);
    cyc("hlt_p4", 3'd4, 8'h10, 1'b1);
    repeat (11) cyc("hlt_hold", 3'd4, 8'h00, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.opcode = ADD;
    cyc("hlt_rst", 3'd0, 8'h80, 1'b0);
    cyc("pre_stall", 3'd1, 8'hC0, 1'b0);
    bus.stall = 1'b1;
    repeat (3) cyc("stall", 3'd2, 8'hE0, 1'b0);
    bus.stall = 1'b0;
    cyc("stall_end", 3'd2, 8'hE0, 1'b0);
    cyc("resume", 3'd3, 8'hE0, 1'b0);
    cyc("resume", 3'd4, 8'h10, 1'b0);
    cyc("resume", 3'd5, 8'h40, 1'b0);
    bus.stall = 1'b1;
    rst_n = 1'b0;
    cyc("rst_stall_pre", 3'd6, 8'h40, 1'b0);
    rst_n = 1'b1;
    cyc("rst_stall", 3'd0, 8'h80, 1'b0);
    bus.stall = 1'b0;
    bus.opcode = HLT;
    for (int i = 0; i < 4; i++) cyc("hlt_st_pre", 3'(i), t_add[i], 1'b0);
    bus.stall = 1'b1;
    repeat (2) cyc("hlt_deferred", 3'd4, 8'h10, 1'b1);
    bus.stall = 1'b0;
    cyc("hlt_enter", 3'd4, 8'h10, 1'b1);
    repeat (2) cyc("hlt_after", 3'd4, 8'h00, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
